// File: rtl/text_cursor_ctrl.sv
// Write-side controller for the text character RAM: decodes UART bytes and drives cursor-managed RAM writes.
// Optional feature: define TEXT_CLEAR_ON_RESET_EN to sweep the screen with spaces after every reset.
module text_cursor_ctrl #(
   parameter int COLS  = 32,
   parameter int ROWS  = 4,
   parameter int COL_W = 5,
   parameter int ROW_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             ram_we,
   output logic [ROW_W-1:0] ram_row,
   output logic [COL_W-1:0] ram_col,
   output logic [7:0]       ram_wdata,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col,
   output logic             busy
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [7:0]       CH_SPACE = 8'h20;
   localparam logic [7:0]       CH_CR    = 8'h0D;
   localparam logic [7:0]       CH_LF    = 8'h0A;
   localparam logic [7:0]       CH_BS    = 8'h08;
   localparam logic [7:0]       CH_FF    = 8'h0C;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] cur_row_q, cur_row_d;
   logic [COL_W-1:0] cur_col_q, cur_col_d;
   logic [ROW_W-1:0] swp_row_q, swp_row_d;
   logic [COL_W-1:0] swp_col_q, swp_col_d;
   logic             swp_done_q, swp_done_d;
   logic             ram_we_q, ram_we_d;
   logic [ROW_W-1:0] ram_row_q, ram_row_d;
   logic [COL_W-1:0] ram_col_q, ram_col_d;
   logic [7:0]       ram_wdata_q, ram_wdata_d;
   logic             rx_ready_q, rx_ready_d;
   logic             busy_q, busy_d;

   logic             accept;
   logic             printable;
   logic [ROW_W-1:0] row_inc;
   logic [COL_W-1:0] col_inc;
   logic [ROW_W-1:0] swp_src_row;
   logic [COL_W-1:0] swp_src_col;
   logic [ROW_W-1:0] swp_nxt_row;
   logic [COL_W-1:0] swp_nxt_col;
   logic             swp_nxt_done;

   assign accept    = rx_valid && rx_ready_q;
   assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
   assign row_inc   = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + 1'b1;
   assign col_inc   = (cur_col_q == COL_LAST) ? '0 : cur_col_q + 1'b1;

   // The FF accept itself writes cell (0,0), so the sweep pointer steps from
   // the origin when idle and from the live pointer while clearing.
   assign swp_src_row = (state_q == S_IDLE) ? '0 : swp_row_q;
   assign swp_src_col = (state_q == S_IDLE) ? '0 : swp_col_q;

   always_comb begin
      swp_nxt_row  = swp_src_row;
      swp_nxt_col  = swp_src_col + 1'b1;
      swp_nxt_done = 1'b0;
      if (swp_src_col == COL_LAST) begin
         swp_nxt_col = '0;
         if (swp_src_row == ROW_LAST) begin
            swp_nxt_row  = '0;
            swp_nxt_done = 1'b1;
         end else begin
            swp_nxt_row = swp_src_row + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_row_d   = cur_row_q;
      cur_col_d   = cur_col_q;
      swp_row_d   = swp_row_q;
      swp_col_d   = swp_col_q;
      swp_done_d  = swp_done_q;
      ram_we_d    = 1'b0;
      ram_row_d   = ram_row_q;
      ram_col_d   = ram_col_q;
      ram_wdata_d = ram_wdata_q;
      rx_ready_d  = rx_ready_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (printable) begin
                  ram_we_d    = 1'b1;
                  ram_row_d   = cur_row_q;
                  ram_col_d   = cur_col_q;
                  ram_wdata_d = rx_data;
                  cur_col_d   = col_inc;
                  if (cur_col_q == COL_LAST) begin
                     cur_row_d = row_inc;
                  end
               end else begin
                  case (rx_data)
                     CH_CR: begin
                        cur_col_d = '0;
                     end
                     CH_LF: begin
                        cur_col_d = '0;
                        cur_row_d = row_inc;
                     end
                     CH_BS: begin
                        if (cur_col_q != '0) begin
                           ram_we_d    = 1'b1;
                           ram_row_d   = cur_row_q;
                           ram_col_d   = cur_col_q - 1'b1;
                           ram_wdata_d = CH_SPACE;
                           cur_col_d   = cur_col_q - 1'b1;
                        end else if (cur_row_q != '0) begin
                           ram_we_d    = 1'b1;
                           ram_row_d   = cur_row_q - 1'b1;
                           ram_col_d   = COL_LAST;
                           ram_wdata_d = CH_SPACE;
                           cur_row_d   = cur_row_q - 1'b1;
                           cur_col_d   = COL_LAST;
                        end
                     end
                     CH_FF: begin
                        state_d     = S_CLEAR;
                        rx_ready_d  = 1'b0;
                        busy_d      = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_row_d   = '0;
                        ram_col_d   = '0;
                        ram_wdata_d = CH_SPACE;
                        swp_row_d   = swp_nxt_row;
                        swp_col_d   = swp_nxt_col;
                        swp_done_d  = swp_nxt_done;
                     end
                     default: begin
                     end
                  endcase
               end
            end
         end

         S_CLEAR: begin
            if (swp_done_q) begin
               state_d    = S_IDLE;
               rx_ready_d = 1'b1;
               busy_d     = 1'b0;
               cur_row_d  = '0;
               cur_col_d  = '0;
               swp_row_d  = '0;
               swp_col_d  = '0;
               swp_done_d = 1'b0;
            end else begin
               ram_we_d    = 1'b1;
               ram_row_d   = swp_row_q;
               ram_col_d   = swp_col_q;
               ram_wdata_d = CH_SPACE;
               swp_row_d   = swp_nxt_row;
               swp_col_d   = swp_nxt_col;
               swp_done_d  = swp_nxt_done;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
`ifdef TEXT_CLEAR_ON_RESET_EN
         state_q    <= S_CLEAR;
         rx_ready_q <= 1'b0;
         busy_q     <= 1'b1;
`else
         state_q    <= S_IDLE;
         rx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
`endif
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         swp_row_q   <= '0;
         swp_col_q   <= '0;
         swp_done_q  <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_row_q   <= '0;
         ram_col_q   <= '0;
         ram_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         busy_q      <= busy_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         swp_row_q   <= swp_row_d;
         swp_col_q   <= swp_col_d;
         swp_done_q  <= swp_done_d;
         ram_we_q    <= ram_we_d;
         ram_row_q   <= ram_row_d;
         ram_col_q   <= ram_col_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign busy      = busy_q;
   assign ram_we    = ram_we_q;
   assign ram_row   = ram_row_q;
   assign ram_col   = ram_col_q;
   assign ram_wdata = ram_wdata_q;
   assign cur_row   = cur_row_q;
   assign cur_col   = cur_col_q;

endmodule

// File: doc/text_cursor_ctrl.md
# text_cursor_ctrl

Write-side controller for the character RAM behind the VGA text display. It takes received bytes from the UART, decodes printable characters and a small set of control codes, and sequences writes into the dual-port character RAM at a managed cursor position. It replaces ad-hoc cursor logic at the top level and owns the RAM write port exclusively.

## Interface
- `COLS`, 32, columns in the text grid.
- `ROWS`, 4, rows in the text grid.
- `COL_W`, 5, column address width; must satisfy 2^COL_W ≥ COLS.
- `ROW_W`, 2, row address width; must satisfy 2^ROW_W ≥ ROWS.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  single-cycle strobe: `rx_data` holds a byte.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  high when a byte will be accepted this cycle.
- `ram_we`  out  1  character RAM write enable.
- `ram_row`  out  ROW_W  write row address.
- `ram_col`  out  COL_W  write column address.
- `ram_wdata`  out  8  write data.
- `cur_row`  out  ROW_W  current cursor row.
- `cur_col`  out  COL_W  current cursor column.
- `busy`  out  1  high while a clear sweep is in progress.

## Operation
- The block has two states:
  - IDLE: `rx_ready` = 1.
  - CLEAR: `rx_ready` = 0, `busy` = 1.
- A byte is accepted when `rx_valid` and `rx_ready` are both high. In CLEAR, `rx_valid` is ignored and the byte is dropped (not queued).
- Decoding of an accepted byte:
  - 0x20–0x7E (printable): write the byte at (`cur_row`, `cur_col`), then advance the cursor.
  - 0x0D (CR): `cur_col` ← 0. No write.
  - 0x0A (LF): `cur_col` ← 0, row advances. No write.
  - 0x08 (BS): cursor retreats, then 0x20 is written at the new position. At (0,0) BS is a full no-op: no write, cursor unchanged.
  - 0x0C (FF): enter CLEAR.
  - Any other code is ignored: no write, cursor unchanged.
- Cursor advance:
  - If `cur_col` < COLS−1: `cur_col`+1.
  - Otherwise `cur_col` ← 0 and row advances.
  - Row advance: `cur_row`+1, wrapping from ROWS−1 to 0. There is no scrolling; old text is overwritten.
- Cursor retreat:
  - If `cur_col` > 0: `cur_col`−1.
  - Else if `cur_row` > 0: `cur_row`−1, `cur_col` ← COLS−1.
- CLEAR sweep:
  - Writes 0x20 to every cell in row-major order, (0,0) through (ROWS−1, COLS−1), one cell per cycle.
  - After the last write the cursor becomes (0,0) and the block returns to IDLE.
- `ram_row`, `ram_col` and `ram_wdata` hold their last values whenever `ram_we` = 0.

## Timing
- All outputs are registered.
- Reset values: `ram_we` 0, `ram_row` 0, `ram_col` 0, `ram_wdata` 0x00, `cur_row` 0, `cur_col` 0. Remaining reset values are given under Configuration.
- Write latency:
  - A byte accepted in cycle T produces `ram_we` = 1 in cycle T+1, carrying the pre-advance address.
  - For BS, the address carried is the post-retreat position.
  - `cur_row`/`cur_col` show the updated position from T+1.
- Throughput is one byte per cycle in IDLE. Back-to-back accepts are legal and each one produces its own write.
- FF accepted in cycle T:
  - `rx_ready` falls at T+1.
  - Sweep writes occur in cycles T+1 … T+ROWS·COLS.
  - `rx_ready` returns to 1 and the cursor reads (0,0) at T+ROWS·COLS+1.
- Reset asserted mid-sweep aborts the sweep immediately. Cells already written stay written.

## Configuration
- `TEXT_CLEAR_ON_RESET_EN`:
  - Defined: the reset state is CLEAR with the sweep counter at 0, so `rx_ready` resets to 0 and `busy` to 1. After reset deasserts, the block performs a full ROWS·COLS-cycle 0x20 sweep before accepting input.
  - Undefined: the reset state is IDLE, so `rx_ready` resets to 1 and `busy` to 0. RAM contents are untouched.

## Test plan
All scenarios use COLS=32, ROWS=4, macro undefined unless stated.
- Send 'A' (0x41) after reset → one cycle with `ram_we`=1, address (0,0), data 0x41; cursor then (0,1).
- Send 32 printable bytes, then one more → writes at (0,0)…(0,31); the 33rd byte writes at (1,0); cursor (1,1). From cursor (3,31), a printable byte wraps the cursor to (0,0).
- From cursor (2,5):
  - CR → cursor (2,0), no `ram_we`.
  - LF → cursor (3,0).
  - LF again → cursor (0,0).
- BS cases:
  - At (1,0): write 0x20 at (0,31), cursor (0,31).
  - At (0,0): no `ram_we`, cursor (0,0).
  - Byte 0x07: ignored.
- FF at cycle T, with `rx_valid` pulsed mid-sweep → exactly 128 consecutive writes of 0x20 in row-major order; the mid-sweep byte is dropped; `rx_ready`=1 and cursor (0,0) at T+129.
- With `TEXT_CLEAR_ON_RESET_EN` defined: release reset → 128 writes of 0x20; `rx_ready` low throughout, then high.
